// File: rtl/ft_tx_drain.sv
// ft_tx_drain: drains bytes from a fall-through dual-clock FIFO and drives the
// FT2232H 245 synchronous-FIFO transmit pins in the 60 MHz CLKOUT domain.
// A 2-entry skid buffer (head/tail) absorbs TXE# deassertion without losing or
// repeating bytes. After a write burst, once the link has sat idle for
// FLUSH_TIMEOUT clocks, SIWU# is pulsed low for one clock to push out the
// chip's partial packet.
//
// Ports:
//   clk_i           FT2232H CLKOUT, also the FIFO read clock
//   reset_i         asynchronous active-high reset
//   enable_i        permits new pops from the FIFO
//   fifo_rd_en_o    FIFO pop; fifo_rd_data_i is valid in the same cycle
//   fifo_rd_data_i  FIFO fall-through data
//   fifo_rd_empty_i FIFO empty flag
//   ft_txe_n_i      FT2232H TXE#, low when the chip can take a byte
//   ft_data_o       byte presented to the chip (skid buffer head)
//   ft_wr_n_o       FT2232H WR#, low whenever the skid buffer holds data
//   ft_siwu_n_o     FT2232H SIWU#, one-clock low pulse after idle timeout
//   tx_count_o      bytes accepted by the chip, wraps
//   busy_o          skid buffer non-empty or flush in progress
//
// state  | meaning
// IDLE   | nothing sent since the last flush
// ACTIVE | bytes sent, timing the idle gap before flushing
// FLUSH  | SIWU# low for this one cycle, pops blocked
module ft_tx_drain #(
    parameter int DSIZE         = 8,
    parameter int FLUSH_TIMEOUT = 64,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    output logic             fifo_rd_en_o,
    input  logic [DSIZE-1:0] fifo_rd_data_i,
    input  logic             fifo_rd_empty_i,
    input  logic             ft_txe_n_i,
    output logic [DSIZE-1:0] ft_data_o,
    output logic             ft_wr_n_o,
    output logic             ft_siwu_n_o,
    output logic [CNT_W-1:0] tx_count_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [15:0] IDLE_LAST = 16'(FLUSH_TIMEOUT - 1);

    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    logic [15:0]      idle_q, idle_d;
    logic             dirty_q, dirty_d;
    logic             siwu_n_q, siwu_n_d;
    state_t           state_q, state_d;

    logic pop;
    logic acc;
    logic idle_cond;

    // All handshake outputs decode from registers so the FT2232H never sees
    // a combinational path from TXE# back to WR#.
    assign fifo_rd_en_o = enable_i & ~fifo_rd_empty_i & (cnt_q != 2'd2) &
                          (state_q != ST_FLUSH);
    assign ft_data_o    = head_q;
    assign ft_wr_n_o    = (cnt_q == 2'd0);
    assign ft_siwu_n_o  = siwu_n_q;
    assign tx_count_o   = tx_count_q;
    assign busy_o       = (cnt_q != 2'd0) | (state_q == ST_FLUSH);

    assign pop       = fifo_rd_en_o;
    assign acc       = (cnt_q != 2'd0) & ~ft_txe_n_i;
    assign idle_cond = (cnt_q == 2'd0) & fifo_rd_empty_i & ~acc;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        tx_count_d = tx_count_q + {{(CNT_W-1){1'b0}}, acc};
        idle_d     = idle_q;
        dirty_d    = dirty_q;
        state_d    = state_q;

        unique case ({pop, acc})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = fifo_rd_data_i;
                else               tail_d = fifo_rd_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count holds; the popped byte lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    head_d = fifo_rd_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_rd_data_i;
                end
            end
            default: ;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    dirty_d = 1'b1;
                    idle_d  = 16'd0;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (idle_cond) begin
                    if (idle_q == IDLE_LAST) begin
                        idle_d  = 16'd0;
                        state_d = ST_FLUSH;
                    end else begin
                        idle_d = idle_q + 16'd1;
                    end
                end else begin
                    idle_d = 16'd0;
                end
            end
            ST_FLUSH: begin
                dirty_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        siwu_n_d = (state_d != ST_FLUSH);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= 2'd0;
            tx_count_q <= '0;
            idle_q     <= 16'd0;
            dirty_q    <= 1'b0;
            siwu_n_q   <= 1'b1;
            state_q    <= ST_IDLE;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            tx_count_q <= tx_count_d;
            idle_q     <= idle_d;
            dirty_q    <= dirty_d;
            siwu_n_q   <= siwu_n_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_ft_tx_drain.sv
// Bench for ft_tx_drain: a FIFO model feeds the design, a posedge monitor
// records pops, accepted bytes and SIWU# pulses, and directed scenario tasks
// compare the recorded behaviour with hand-computed expectations.
module tb_ft_tx_drain;

    localparam int TO = 64;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       enable_i = 1'b0;
    logic       ft_txe_n_i = 1'b1;
    logic [7:0] fifo_rd_data_i;
    logic       fifo_rd_empty_i;

    logic        fifo_rd_en_o, ft_wr_n_o, ft_siwu_n_o, busy_o;
    logic [7:0]  ft_data_o;
    logic [31:0] tx_count_o;

    logic        rd_en4, wr_n4, siwu_n4, busy4;
    logic [7:0]  data4;
    logic [3:0]  tx_count4;

    always #5 clk_i = ~clk_i;

    ft_tx_drain #(.DSIZE(8), .FLUSH_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
        .fifo_rd_en_o(fifo_rd_en_o), .fifo_rd_data_i(fifo_rd_data_i),
        .fifo_rd_empty_i(fifo_rd_empty_i), .ft_txe_n_i(ft_txe_n_i),
        .ft_data_o(ft_data_o), .ft_wr_n_o(ft_wr_n_o), .ft_siwu_n_o(ft_siwu_n_o),
        .tx_count_o(tx_count_o), .busy_o(busy_o)
    );

    ft_tx_drain #(.DSIZE(8), .FLUSH_TIMEOUT(TO), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
        .fifo_rd_en_o(rd_en4), .fifo_rd_data_i(fifo_rd_data_i),
        .fifo_rd_empty_i(fifo_rd_empty_i), .ft_txe_n_i(ft_txe_n_i),
        .ft_data_o(data4), .ft_wr_n_o(wr_n4), .ft_siwu_n_o(siwu_n4),
        .tx_count_o(tx_count4), .busy_o(busy4)
    );

    // FIFO model: bench pushes at negedge, monitor pops with NBA at posedge.
    logic [7:0] fifo_mem [0:511];
    logic [8:0] wr_ptr = 9'd0;
    logic [8:0] rd_ptr = 9'd0;
    assign fifo_rd_empty_i = (rd_ptr == wr_ptr);
    assign fifo_rd_data_i  = fifo_mem[rd_ptr];

    // Monitor state (written only by the monitor).
    logic [7:0] rx_mem [0:511];
    int rx_n = 0, pops = 0, accs = 0, bcnt = 0, max_b = 0;
    int siwu_lows = 0, siwu_cyc = 0, viol_full = 0, viol_wr = 0;
    int cyc = 0, first_pop = 0, first_acc = 0, last_acc = 0;

    always @(posedge clk_i) begin
        logic acc;
        if (reset_i) begin
            rd_ptr <= 9'd0;
            rx_n = 0; pops = 0; accs = 0; bcnt = 0; max_b = 0;
            siwu_lows = 0; siwu_cyc = 0; viol_full = 0; viol_wr = 0; cyc = 0;
            first_pop = 0; first_acc = 0; last_acc = 0;
        end else begin
            cyc = cyc + 1;
            if (ft_wr_n_o !== (bcnt == 0)) viol_wr = viol_wr + 1;
            if (fifo_rd_en_o && bcnt == 2) viol_full = viol_full + 1;
            acc = !ft_wr_n_o && !ft_txe_n_i;
            if (acc) begin
                rx_mem[rx_n[8:0]] = ft_data_o;
                rx_n = rx_n + 1;
                if (accs == 0) first_acc = cyc;
                last_acc = cyc;
                accs = accs + 1;
                bcnt = bcnt - 1;
            end
            if (fifo_rd_en_o) begin
                rd_ptr <= rd_ptr + 9'd1;
                if (pops == 0) first_pop = cyc;
                pops = pops + 1;
                bcnt = bcnt + 1;
            end
            if (bcnt > max_b) max_b = bcnt;
            if (!ft_siwu_n_o) begin
                siwu_lows = siwu_lows + 1;
                siwu_cyc = cyc;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 9'd1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        wr_ptr = 9'd0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_n < n; i++) @(negedge clk_i);
    endtask

    task automatic wait_pops(input int n, input int budget);
        for (int i = 0; i < budget && pops < n; i++) @(negedge clk_i);
    endtask

    task automatic test_reset();
        enable_i = 1'b1;
        ft_txe_n_i = 1'b1;
        do_reset();
        #1;
        vectors++; if (ft_wr_n_o !== 1'b1) begin miscompares++; $display("FAIL reset_wr_n got %b want 1", ft_wr_n_o); end
        vectors++; if (ft_siwu_n_o !== 1'b1) begin miscompares++; $display("FAIL reset_siwu got %b want 1", ft_siwu_n_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_o); end
        vectors++; if (tx_count_o !== 32'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", tx_count_o); end
        vectors++; if (ft_data_o !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", ft_data_o); end
        vectors++; if (fifo_rd_en_o !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en_o); end
    endtask

    task automatic test_idle_empty();
        repeat (100) @(negedge clk_i);
        vectors++; if (pops !== 0) begin miscompares++; $display("FAIL idle_pops got %0d want 0", pops); end
        vectors++; if (accs !== 0) begin miscompares++; $display("FAIL idle_accepts got %0d want 0", accs); end
        vectors++; if (siwu_lows !== 0) begin miscompares++; $display("FAIL idle_siwu got %0d want 0", siwu_lows); end
        vectors++; if (viol_wr !== 0) begin miscompares++; $display("FAIL idle_wr_n got %0d bad cycles want 0", viol_wr); end
    endtask

    task automatic test_basic();
        int bad;
        do_reset();
        ft_txe_n_i = 1'b0;
        enable_i = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        wait_rx(16, 100);
        repeat (TO + 10) @(negedge clk_i);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rx_mem[i] !== 8'(i + 1)) bad++;
        vectors++; if (rx_n !== 16) begin miscompares++; $display("FAIL basic_rx_count got %0d want 16", rx_n); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL basic_order got %0d wrong bytes want 0", bad); end
        vectors++; if (tx_count_o !== 32'd16) begin miscompares++; $display("FAIL basic_tx_count got %0d want 16", tx_count_o); end
        vectors++; if (first_acc - first_pop !== 1) begin miscompares++; $display("FAIL basic_latency got %0d want 1", first_acc - first_pop); end
        vectors++; if (last_acc - first_acc !== 15) begin miscompares++; $display("FAIL basic_throughput got %0d want 15", last_acc - first_acc); end
        vectors++; if (siwu_lows !== 1) begin miscompares++; $display("FAIL basic_siwu_pulses got %0d want 1", siwu_lows); end
        // SIWU# drops at edge last_accept+TO, so it is seen low at the next sample.
        vectors++; if (siwu_cyc - last_acc !== TO + 1) begin miscompares++; $display("FAIL basic_siwu_delay got %0d want %0d", siwu_cyc - last_acc, TO + 1); end
        vectors++; if (viol_wr !== 0) begin miscompares++; $display("FAIL basic_wr_n got %0d bad cycles want 0", viol_wr); end
        repeat (150) @(negedge clk_i);
        vectors++; if (siwu_lows !== 1) begin miscompares++; $display("FAIL basic_siwu_quiet got %0d want 1", siwu_lows); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end got %b want 0", busy_o); end
    endtask

    task automatic test_txe_toggle();
        int bad;
        do_reset();
        enable_i = 1'b1;
        for (int i = 0; i < 256; i++) push(8'(i));
        for (int i = 0; i < 2000 && rx_n < 256; i++) begin
            ft_txe_n_i = ((i % 7) >= 4);
            @(negedge clk_i);
        end
        ft_txe_n_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) if (rx_mem[i] !== 8'(i)) bad++;
        vectors++; if (rx_n !== 256) begin miscompares++; $display("FAIL toggle_rx_count got %0d want 256", rx_n); end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL toggle_order got %0d wrong bytes want 0", bad); end
        vectors++; if (tx_count_o !== 32'd256) begin miscompares++; $display("FAIL toggle_tx_count got %0d want 256", tx_count_o); end
        vectors++; if (viol_full !== 0) begin miscompares++; $display("FAIL toggle_pop_when_full got %0d want 0", viol_full); end
        vectors++; if (viol_wr !== 0) begin miscompares++; $display("FAIL toggle_wr_n got %0d bad cycles want 0", viol_wr); end
        vectors++; if (max_b !== 2) begin miscompares++; $display("FAIL toggle_max_fill got %0d want 2", max_b); end
    endtask

    task automatic test_enable_drain();
        do_reset();
        ft_txe_n_i = 1'b1;
        enable_i = 1'b1;
        push(8'hA5); push(8'h5A); push(8'h77);
        wait_pops(2, 20);
        repeat (3) @(negedge clk_i);
        vectors++; if (pops !== 2) begin miscompares++; $display("FAIL drain_fill_pops got %0d want 2", pops); end
        enable_i = 1'b0;
        ft_txe_n_i = 1'b0;
        @(negedge clk_i);
        vectors++; if (rx_n !== 1 || rx_mem[0] !== 8'hA5) begin miscompares++; $display("FAIL drain_first got n=%0d %h want n=1 a5", rx_n, rx_mem[0]); end
        vectors++; if (busy_o !== 1'b1 || ft_data_o !== 8'h5A) begin miscompares++; $display("FAIL drain_mid got busy=%b %h want busy=1 5a", busy_o, ft_data_o); end
        @(negedge clk_i);
        vectors++; if (rx_n !== 2 || rx_mem[1] !== 8'h5A) begin miscompares++; $display("FAIL drain_second got n=%0d %h want n=2 5a", rx_n, rx_mem[1]); end
        vectors++; if (busy_o !== 1'b0 || ft_wr_n_o !== 1'b1) begin miscompares++; $display("FAIL drain_done got busy=%b wr_n=%b want 0 1", busy_o, ft_wr_n_o); end
        repeat (10) @(negedge clk_i);
        vectors++; if (pops !== 2 || fifo_rd_en_o !== 1'b0) begin miscompares++; $display("FAIL drain_no_pop got pops=%0d rd_en=%b want 2 0", pops, fifo_rd_en_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ft_txe_n_i = 1'b0;
        enable_i = 1'b1;
        push(8'h33);
        wait_rx(1, 20);
        @(negedge clk_i);
        vectors++; if (tx_count_o !== 32'd1) begin miscompares++; $display("FAIL midrst_pre_count got %0d want 1", tx_count_o); end
        ft_txe_n_i = 1'b1;
        push(8'h11); push(8'h22);
        wait_pops(3, 20);
        @(negedge clk_i);
        vectors++; if (busy_o !== 1'b1 || ft_wr_n_o !== 1'b0) begin miscompares++; $display("FAIL midrst_held got busy=%b wr_n=%b want 1 0", busy_o, ft_wr_n_o); end
        #2 reset_i = 1'b1;
        wr_ptr = 9'd0;
        #1;
        vectors++; if (ft_wr_n_o !== 1'b1) begin miscompares++; $display("FAIL midrst_wr_n got %b want 1", ft_wr_n_o); end
        vectors++; if (tx_count_o !== 32'd0) begin miscompares++; $display("FAIL midrst_count got %0d want 0", tx_count_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy_o); end
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        ft_txe_n_i = 1'b0;
        repeat (10) @(negedge clk_i);
        vectors++; if (accs !== 0 || ft_wr_n_o !== 1'b1) begin miscompares++; $display("FAIL midrst_stale got accepts=%0d wr_n=%b want 0 1", accs, ft_wr_n_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        ft_txe_n_i = 1'b0;
        enable_i = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(8'hC0 + i));
        wait_rx(17, 100);
        @(negedge clk_i);
        vectors++; if (tx_count_o !== 32'd17) begin miscompares++; $display("FAIL wrap_count32 got %0d want 17", tx_count_o); end
        vectors++; if (tx_count4 !== 4'd1) begin miscompares++; $display("FAIL wrap_count4 got %0d want 1", tx_count4); end
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_basic();
        test_txe_toggle();
        test_enable_drain();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ft_tx_drain.md
Name: ft_tx_drain

Overview:
- Downstream consumer of the read side of the dual-clock FIFO. The FIFO runs in fall-through mode.
- Drains bytes from the FIFO and drives the FT2232H 245 synchronous-FIFO transmit pins (data, WR#, SIWU#) in the FT2232H 60 MHz clock domain.
- A 2-entry skid buffer absorbs TXE# deassertion, so no byte is lost or duplicated.
- Issues a send-immediate pulse after the link has been idle for a set time following a write.

Parameters:
- DSIZE, 8, data width; must equal the FIFO DSIZE.
- FLUSH_TIMEOUT, 64, idle clocks after the last accepted byte before SIWU# pulses; legal range 2..65535.
- CNT_W, 32, width of the transmitted-byte counter.

Ports:
- clk_i  in  1  FT2232H CLKOUT, 60 MHz; the FIFO read clock.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  permits new pops from the FIFO.
- fifo_rd_en_o  out  1  FIFO read enable/pop; the FIFO data is valid in the same cycle.
- fifo_rd_data_i  in  DSIZE  FIFO fall-through data; meaningful only while fifo_rd_en_o=1.
- fifo_rd_empty_i  in  1  FIFO empty flag.
- ft_txe_n_i  in  1  FT2232H TXE#, active low; chip can accept a byte.
- ft_data_o  out  DSIZE  byte presented to the FT2232H.
- ft_wr_n_o  out  1  FT2232H WR#, active low.
- ft_siwu_n_o  out  1  FT2232H SIWU#, active low.
- tx_count_o  out  CNT_W  number of bytes accepted by the FT2232H; wraps.
- busy_o  out  1  skid buffer non-empty or flush pending.

Behaviour:
- Reset state (async, immediate): buffer count=0; ft_data_o=0; ft_wr_n_o=1; ft_siwu_n_o=1; tx_count_o=0; busy_o=0; idle counter=0; dirty flag=0; state=IDLE.
- Skid buffer: 2 entries, head and tail registers, count 0..2. ft_data_o is the head register.
- ft_wr_n_o = (count==0). It is decoded from registers only, never from any input.
- Pop rule (combinational, registers only):
  - fifo_rd_en_o = enable_i & ~fifo_rd_empty_i & (count<2) & (state!=FLUSH).
  - fifo_rd_data_i is captured at the clock edge where fifo_rd_en_o=1.
- Accept rule: a byte is accepted at a rising edge where ft_wr_n_o==0 and ft_txe_n_i==0.
  - On accept: head <= tail (or the popped byte), count decrements, tx_count_o increments by 1 (mod 2^CNT_W).
- Simultaneous pop and accept: count is unchanged. The popped byte enters the correct slot:
  - count=1 before the edge: becomes the new head;
  - count=2 before the edge: becomes the new tail.
- Order is strictly FIFO; no byte is dropped or duplicated.
- Latency: a byte popped at edge N is on ft_data_o with ft_wr_n_o=0 after edge N. It is accepted at edge N+1 at the earliest.
- Throughput: steady state with TXE# low and the FIFO non-empty is 1 byte/clk.
- ft_txe_n_i high: ft_wr_n_o stays low while data is held; the chip ignores the write. The buffer fills to 2, then popping stops.
- enable_i low: no new pops. Buffered bytes still drain.
- States:
  - IDLE: no unflushed data.
    - Any accept sets dirty=1, clears the idle counter and moves to ACTIVE.
  - ACTIVE:
    - Idle counter increments each clock with no accept while count==0 and fifo_rd_empty_i=1.
    - Otherwise the idle counter clears.
    - When idle counter == FLUSH_TIMEOUT-1: go to FLUSH.
  - FLUSH: one cycle.
    - ft_siwu_n_o=0 (registered, exactly 1 clk low). Pops are blocked; ft_wr_n_o=1 because count==0.
    - Then dirty=0 and the state returns to IDLE.
- busy_o = (count!=0) | (state==FLUSH).
- Reset mid-transfer: buffered bytes are discarded and all outputs take reset values at once. The FIFO is reset alongside by the system.

Test Plan:
- Reset, then push 0x01..0x10 into the FIFO with TXE# held low → ft_data_o sequence 0x01..0x10 on 16 consecutive accepts. tx_count_o=16. Exactly one SIWU# low pulse, FLUSH_TIMEOUT clocks after the last accept.
- Stream 0x00..0xFF; toggle TXE# high for 3 clks every 7 clks → received sequence exactly 0x00..0xFF, no gaps or repeats. fifo_rd_en_o never asserts with count==2.
- FIFO empty, enable_i=1 → fifo_rd_en_o=0, ft_wr_n_o=1, ft_siwu_n_o=1 indefinitely. Likewise after reset with no traffic.
- Load 2 bytes (0xA5, 0x5A) with TXE# high, drop enable_i, then lower TXE# → 0xA5 then 0x5A accepted. No further pops. busy_o falls after the second accept.
- Assert reset_i while count==2 and TXE# high → ft_wr_n_o=1, tx_count_o=0, busy_o=0 immediately. After release, no stale byte is presented.
- Set CNT_W=4 and send 17 bytes → tx_count_o=1 (wrap).
